button_debouncer: RTL

- Consumes the divided square wave from the game's 1 kHz clock divider, recovering it as a one-cycle sample strobe in the fast clock domain.
- Uses that strobe to debounce NUM_BUTTONS raw push-button inputs (mole-hit buttons).
- Outputs per button: a clean level, plus single-cycle press and release pulses for the game FSM.
- Sits between the board pins/divider output and the game controller.

---
 rtl/game_pkg.sv | 9 +
 rtl/button_debouncer_if.sv | 23 ++
 rtl/debounce_channel.sv | 85 ++++++++
 rtl/button_debouncer.sv | 55 +++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the whack-a-mole game blocks.
package game_pkg;

    typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} ch_state_t;

    localparam int DEBOUNCE_TICKS_DEFAULT = 10;
    localparam int SYS_CLK_HZ             = 100_000_000;

endpackage

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: sample clock, raw buttons and debounced outputs of the debouncer.
interface button_debouncer_if #(
    parameter int NUM_BUTTONS = 4
);

    logic                   sample_clk;
    logic [NUM_BUTTONS-1:0] btn_raw;
    logic                   tick;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_press;
    logic [NUM_BUTTONS-1:0] btn_release;

    modport master (
        output sample_clk, btn_raw,
        input  tick, btn_level, btn_press, btn_release
    );

    modport slave (
        input  sample_clk, btn_raw,
        output tick, btn_level, btn_press, btn_release
    );

endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: one button's agreement FSM, evaluated only on sample ticks.
module debounce_channel
    import game_pkg::*;
#(
    parameter int STABLE_TICKS = DEBOUNCE_TICKS_DEFAULT,
    parameter int CNT_W        = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic s,
    output logic level,
    output logic press,
    output logic released
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

    ch_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             press_n, rel_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= LOW;
            cnt      <= '0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            press    <= press_n;
            released <= rel_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        press_n = 1'b0;
        rel_n   = 1'b0;
        if (tick) begin
            unique case (state)
                LOW: if (s) begin
                    if (STABLE_TICKS == 1) begin
                        state_n = HIGH;
                        press_n = 1'b1;
                    end else begin
                        state_n = CHK_HIGH;
                        cnt_n   = CNT_W'(1);
                    end
                end
                CHK_HIGH: if (!s) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end else cnt_n = cnt + 1'b1;
                HIGH: if (!s) begin
                    if (STABLE_TICKS == 1) begin
                        state_n = LOW;
                        rel_n   = 1'b1;
                    end else begin
                        state_n = CHK_LOW;
                        cnt_n   = CNT_W'(1);
                    end
                end
                CHK_LOW: if (s) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = LOW;
                    cnt_n   = '0;
                    rel_n   = 1'b1;
                end else cnt_n = cnt + 1'b1;
            endcase
        end
    end

    // A pending change keeps reporting the committed level until it commits.
    assign level = (state == HIGH) || (state == CHK_LOW);

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: recovers a sample strobe from the divided clock and debounces NUM_BUTTONS buttons.
module button_debouncer
    import game_pkg::*;
#(
    parameter int NUM_BUTTONS  = 4,
    parameter int STABLE_TICKS = DEBOUNCE_TICKS_DEFAULT,
    parameter int CNT_W        = 4
) (
    input  logic               clock,
    input  logic               reset,
    button_debouncer_if.slave  bus
);

    logic [1:0]             sc_sync;
    logic                   sc_hist, tick;
    logic [NUM_BUTTONS-1:0] b_meta, b_sync, lvl, prs, rls;

    // sample_clk is sampled as data; its rising edge becomes a one-cycle strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sc_sync <= '0;
            sc_hist <= 1'b0;
            tick    <= 1'b0;
            b_meta  <= '0;
            b_sync  <= '0;
        end else begin
            sc_sync <= {sc_sync[0], bus.sample_clk};
            sc_hist <= sc_sync[1];
            tick    <= sc_sync[1] & ~sc_hist;
            b_meta  <= bus.btn_raw;
            b_sync  <= b_meta;
        end
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .tick     (tick),
            .s        (b_sync[i]),
            .level    (lvl[i]),
            .press    (prs[i]),
            .released (rls[i])
        );
    end

    assign bus.tick        = tick;
    assign bus.btn_level   = lvl;
    assign bus.btn_press   = prs;
    assign bus.btn_release = rls;

endmodule
